// File: rtl/ps2_pkg.sv
// Shared set-2 scan-code constants, receiver state encoding and the scan-code to
// Apple-1 ASCII lookup (bit7 always set on a valid character).
package ps2_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    // Returns {valid, char}; letters are upper case regardless of shift.
    function automatic logic [8:0] ps2_to_ascii(input logic [7:0] code, input logic shift,
                                                input logic ext);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = 8'h00;
        hi = 8'h00;
        if (ext) begin
            case (code)
                8'h6B:   lo = 8'h88;
                8'h74:   lo = 8'h95;
                8'h5A:   lo = 8'h8D;
                default: lo = 8'h00;
            endcase
            return {lo != 8'h00, lo};
        end
        case (code)
            8'h1C: lo = 8'hC1;  8'h32: lo = 8'hC2;  8'h21: lo = 8'hC3;  8'h23: lo = 8'hC4;
            8'h24: lo = 8'hC5;  8'h2B: lo = 8'hC6;  8'h34: lo = 8'hC7;  8'h33: lo = 8'hC8;
            8'h43: lo = 8'hC9;  8'h3B: lo = 8'hCA;  8'h42: lo = 8'hCB;  8'h4B: lo = 8'hCC;
            8'h3A: lo = 8'hCD;  8'h31: lo = 8'hCE;  8'h44: lo = 8'hCF;  8'h4D: lo = 8'hD0;
            8'h15: lo = 8'hD1;  8'h2D: lo = 8'hD2;  8'h1B: lo = 8'hD3;  8'h2C: lo = 8'hD4;
            8'h3C: lo = 8'hD5;  8'h2A: lo = 8'hD6;  8'h1D: lo = 8'hD7;  8'h22: lo = 8'hD8;
            8'h35: lo = 8'hD9;  8'h1A: lo = 8'hDA;
            8'h45: begin lo = 8'hB0; hi = 8'hA9; end
            8'h16: begin lo = 8'hB1; hi = 8'hA1; end
            8'h1E: begin lo = 8'hB2; hi = 8'hC0; end
            8'h26: begin lo = 8'hB3; hi = 8'hA3; end
            8'h25: begin lo = 8'hB4; hi = 8'hA4; end
            8'h2E: begin lo = 8'hB5; hi = 8'hA5; end
            8'h36: begin lo = 8'hB6; hi = 8'hDE; end
            8'h3D: begin lo = 8'hB7; hi = 8'hA6; end
            8'h3E: begin lo = 8'hB8; hi = 8'hAA; end
            8'h46: begin lo = 8'hB9; hi = 8'hA8; end
            8'h4E: begin lo = 8'hAD; hi = 8'hDF; end
            8'h55: begin lo = 8'hBD; hi = 8'hAB; end
            8'h41: begin lo = 8'hAC; hi = 8'hBC; end
            8'h49: begin lo = 8'hAE; hi = 8'hBE; end
            8'h4A: begin lo = 8'hAF; hi = 8'hBF; end
            8'h4C: begin lo = 8'hBB; hi = 8'hBA; end
            8'h52: begin lo = 8'hA7; hi = 8'hA2; end
            8'h29: lo = 8'hA0;
            8'h5A: lo = 8'h8D;
            8'h76: lo = 8'h9B;
            default: lo = 8'h00;
        endcase
        if (hi == 8'h00) hi = lo;
        if (shift) lo = hi;
        return {lo != 8'h00, lo};
    endfunction

endpackage

// File: rtl/ps2_kbd_fifo_if.sv
// CPU-side keyboard register bus: pop strobe, error clear, head character, status.
interface ps2_kbd_fifo_if
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
);
    // kbd_rd is a one-clock strobe: each clock it is high while kbd_count != 0 pops
    // exactly one character; strobes while empty are ignored. No ready back-pressure.
    logic                            kbd_rd;
    logic                            err_clr;
    logic [7:0]                      kbd;
    logic [$clog2(FIFO_DEPTH+1)-1:0] kbd_count;
    logic                            parity_err;
    logic                            frame_err;
    logic                            overflow;
    rx_state_t                       rx_state;

    modport master (output kbd_rd, err_clr,
                    input  kbd, kbd_count, parity_err, frame_err, overflow, rx_state);
    modport slave  (input  kbd_rd, err_clr,
                    output kbd, kbd_count, parity_err, frame_err, overflow, rx_state);
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus run-length filter: the output follows the pin only after
// FILTER_LEN consecutive samples disagree with it.
module ps2_line_filter #(
    parameter int FILTER_LEN = 16
) (
    input  logic clock,
    input  logic kbd_clr,
    input  logic raw,
    output logic filt
);
    localparam int FW = $clog2(FILTER_LEN);

    logic [1:0]    sync;
    logic [FW-1:0] cnt;

    always_ff @(posedge clock or posedge kbd_clr) begin
        if (kbd_clr) begin
            sync <= 2'b11;
            cnt  <= '0;
            filt <= 1'b1;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == filt) begin
                cnt <= '0;
            end else if (cnt == FW'(FILTER_LEN - 1)) begin
                filt <= sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + FW'(1);
            end
        end
    end
endmodule

// File: rtl/ps2_kbd_fifo.sv
// PS/2 keyboard receiver, set-2 decoder and character FIFO for the KBD register.
// Define PS2_EXTENDED_EN to decode E0-prefixed arrow and keypad-enter makes.
module ps2_kbd_fifo
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 20000
) (
    input logic           clock,
    input logic           kbd_clr,
    input logic           ps2_clk_in,
    input logic           ps2_dat_in,
    ps2_kbd_fifo_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic clk_f, dat_f, clk_f_q, fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clock(clock), .kbd_clr(kbd_clr), .raw(ps2_clk_in), .filt(clk_f));
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clock(clock), .kbd_clr(kbd_clr), .raw(ps2_dat_in), .filt(dat_f));

    assign fall = clk_f_q & ~clk_f;

    rx_state_t     state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] tmo_cnt;
    logic          code_vld, perr_ev, ferr_ev;
    logic [7:0]    code;

    always_ff @(posedge clock or posedge kbd_clr) begin
        if (kbd_clr) begin
            state    <= RX_IDLE;
            clk_f_q  <= 1'b1;
            bit_cnt  <= '0;
            shreg    <= '0;
            par      <= 1'b0;
            tmo_cnt  <= '0;
            code_vld <= 1'b0;
            code     <= '0;
            perr_ev  <= 1'b0;
            ferr_ev  <= 1'b0;
        end else begin
            clk_f_q  <= clk_f;
            code_vld <= 1'b0;
            perr_ev  <= 1'b0;
            ferr_ev  <= 1'b0;
            if (fall) begin
                tmo_cnt <= '0;
                unique case (state)
                    RX_IDLE: begin
                        if (!dat_f) begin
                            state   <= RX_DATA;
                            bit_cnt <= '0;
                        end else begin
                            ferr_ev <= 1'b1;
                        end
                    end
                    RX_DATA: begin
                        shreg   <= {dat_f, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        par   <= dat_f;
                        state <= RX_STOP;
                    end
                    RX_STOP: begin
                        state <= RX_IDLE;
                        if (!dat_f) begin
                            ferr_ev <= 1'b1;
                        end else if (^{shreg, par}) begin
                            code_vld <= 1'b1;
                            code     <= shreg;
                        end else begin
                            perr_ev <= 1'b1;
                        end
                    end
                endcase
            end else if (state != RX_IDLE) begin
                if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    state   <= RX_IDLE;
                    tmo_cnt <= '0;
                    ferr_ev <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end
        end
    end

    // Prefix flags persist across frames; ext-prefixed codes never touch shift.
    logic       brk, ext, shift, push_vld;
    logic [7:0] push_char;

    always_ff @(posedge clock or posedge kbd_clr) begin
        if (kbd_clr) begin
            brk       <= 1'b0;
            ext       <= 1'b0;
            shift     <= 1'b0;
            push_vld  <= 1'b0;
            push_char <= '0;
        end else begin
            push_vld <= 1'b0;
            if (code_vld) begin
                if (code == SC_BREAK) begin
                    brk <= 1'b1;
                end else if (code == SC_EXT) begin
                    ext <= 1'b1;
                end else begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                    if (ext) begin
`ifdef PS2_EXTENDED_EN
                        if (!brk) {push_vld, push_char} <= ps2_to_ascii(code, shift, 1'b1);
`endif
                    end else if (code == SC_LSHIFT || code == SC_RSHIFT) begin
                        shift <= ~brk;
                    end else if (!brk) begin
                        {push_vld, push_char} <= ps2_to_ascii(code, shift, 1'b0);
                    end
                end
            end
        end
    end

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          do_pop, do_push;
    logic          parity_err, frame_err, overflow;

    assign do_pop  = bus.kbd_rd && (count != '0);
    assign do_push = push_vld && ((count != FULL_CNT) || do_pop);

    always_ff @(posedge clock or posedge kbd_clr) begin
        if (kbd_clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
            if (perr_ev)          parity_err <= 1'b1;
            else if (bus.err_clr) parity_err <= 1'b0;
            if (ferr_ev)          frame_err <= 1'b1;
            else if (bus.err_clr) frame_err <= 1'b0;
            if (push_vld && !do_push) overflow <= 1'b1;
            else if (bus.err_clr)     overflow <= 1'b0;
        end
    end

    // When full with a simultaneous pop, the write lands in the slot being vacated.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_char;
    end

    assign bus.kbd        = (count != '0) ? mem[rd_ptr] : 8'h00;
    assign bus.kbd_count  = count;
    assign bus.parity_err = parity_err;
    assign bus.frame_err  = frame_err;
    assign bus.overflow   = overflow;
    assign bus.rx_state   = state;
endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// Randomised and directed bench for ps2_kbd_fifo with a queue-based reference model.
module tb_ps2_kbd_fifo;
    import ps2_pkg::*;

    localparam int FILTER_LEN  = 4;
    localparam int FIFO_DEPTH  = 8;
    localparam int TIMEOUT_CYC = 100;
    localparam int HALF        = 8;
    localparam int IDLE        = 24;
`ifdef PS2_EXTENDED_EN
    localparam bit EXT_EN = 1'b1;
`else
    localparam bit EXT_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic kbd_clr = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;
    logic man_rd = 1'b0, mon_rd = 1'b0, err_clr = 1'b0, auto_read = 1'b0;
    int   n_tests = 0, n_fail = 0;
    int   cyc = 0, chg_cyc = 0, lat, s0;
    int   prev_cnt = 0;

    ps2_kbd_fifo_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();
    assign bus.kbd_rd  = man_rd | mon_rd;
    assign bus.err_clr = err_clr;

    ps2_kbd_fifo #(.FILTER_LEN(FILTER_LEN), .FIFO_DEPTH(FIFO_DEPTH),
                   .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clock(clock), .kbd_clr(kbd_clr), .ps2_clk_in(ps2_clk), .ps2_dat_in(ps2_dat),
        .bus(bus));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) begin
        if (int'(bus.kbd_count) != prev_cnt) chg_cyc <= cyc;
        prev_cnt <= int'(bus.kbd_count);
    end

    // Reference model: key maps built from character strings, FIFO as a queue.
    logic [7:0] unsh_map[logic [7:0]];
    logic [7:0] sh_map[logic [7:0]];
    logic [7:0] ext_map[logic [7:0]];
    logic [7:0] exp_q[$];
    logic [7:0] pool[$];
    bit m_shift, m_brk, m_ext, exp_ovf;

    task automatic add_keys(input logic [7:0] sc[$], input string lo, input string hi);
        for (int i = 0; i < sc.size(); i++) begin
            unsh_map[sc[i]] = 8'h80 | 8'(lo[i]);
            sh_map[sc[i]]   = 8'h80 | 8'(hi[i]);
            pool.push_back(sc[i]);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_next();
        if (exp_q.size() == 0) return 8'h00;
        return exp_q.pop_front();
    endfunction

    task automatic model_code(input logic [7:0] c);
        logic [7:0] ch = 8'h00;
        bit hit = 1'b0;
        if (c == 8'hF0) m_brk = 1'b1;
        else if (c == 8'hE0) m_ext = 1'b1;
        else begin
            if (m_ext) begin
                if (EXT_EN && !m_brk && ext_map.exists(c)) begin hit = 1'b1; ch = ext_map[c]; end
            end else if (c == 8'h12 || c == 8'h59) m_shift = !m_brk;
            else if (!m_brk && unsh_map.exists(c)) begin
                hit = 1'b1;
                ch  = m_shift ? sh_map[c] : unsh_map[c];
            end
            m_brk = 1'b0;
            m_ext = 1'b0;
            if (hit) begin
                if (exp_q.size() >= FIFO_DEPTH) exp_ovf = 1'b1;
                else exp_q.push_back(ch);
            end
        end
    endtask

    // Drivers: every task starts and ends on a falling system-clock edge.
    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = bits[i];
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad_par);
        send_bits({1'b1, ~(^code) ^ bad_par, code, 1'b0}, 11);
        ps2_dat = 1'b1;
        repeat (IDLE) @(negedge clock);
    endtask

    task automatic key(input logic [7:0] code);
        model_code(code);
        send_frame(code, 1'b0);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clock);
        err_clr = 1'b0;
        @(negedge clock);
    endtask

    task automatic pop_check(input string name);
        chk(name, bus.kbd, exp_next());
        man_rd = 1'b1;
        @(negedge clock);
        man_rd = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (auto_read && bus.kbd_count != '0) begin
                chk("mon_kbd", bus.kbd, exp_next());
                mon_rd = 1'b1;
                @(negedge clock);
                mon_rd = 1'b0;
            end
        end
    end

    initial begin
        add_keys('{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                   8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
                   8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A},
                 "ABCDEFGHIJKLMNOPQRSTUVWXYZ", "ABCDEFGHIJKLMNOPQRSTUVWXYZ");
        add_keys('{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46},
                 "0123456789", ")!@#$%^&*(");
        add_keys('{8'h4E, 8'h55, 8'h41, 8'h49, 8'h4A, 8'h4C, 8'h52, 8'h29},
                 "-=,./;' ", "_+<>?:\" ");
        unsh_map[8'h5A] = 8'h8D; sh_map[8'h5A] = 8'h8D;
        unsh_map[8'h76] = 8'h9B; sh_map[8'h76] = 8'h9B;
        ext_map[8'h6B] = 8'h88; ext_map[8'h74] = 8'h95; ext_map[8'h5A] = 8'h8D;
        pool.push_back(8'h5A); pool.push_back(8'h76); pool.push_back(8'h05);
        pool.push_back(8'h0D); pool.push_back(8'h6B); pool.push_back(8'h74);
        for (int i = 0; i < 6; i++) begin pool.push_back(8'h12); pool.push_back(8'h59); end

        repeat (3) @(negedge clock);
        chk("rst_kbd", bus.kbd, 0);
        chk("rst_count", bus.kbd_count, 0);
        chk("rst_perr", bus.parity_err, 0);
        chk("rst_ferr", bus.frame_err, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_state", bus.rx_state, RX_IDLE);
        kbd_clr = 1'b0;
        repeat (4) @(negedge clock);

        // A make, break, measure push latency from frame start.
        s0 = cyc;
        key(8'h1C);
        lat = chg_cyc - s0;
        chk("lat_range", int'(lat > 1 && lat < 300), 1);
        if (lat < 2 || lat > 299) lat = 2;
        key(8'hF0); key(8'h1C);
        chk("a_count", bus.kbd_count, exp_q.size());
        pop_check("a_kbd");
        chk("a_empty_kbd", bus.kbd, 0);
        chk("a_empty_cnt", bus.kbd_count, 0);
        pop_check("rd_when_empty");
        chk("rd_empty_cnt", bus.kbd_count, 0);

        // Shift handling.
        key(8'h12); key(8'h1E); key(8'hF0); key(8'h1E); key(8'hF0); key(8'h12); key(8'h1E);
        chk("shift_count", bus.kbd_count, exp_q.size());
        pop_check("shift_at");
        pop_check("shift_two");

        // Bad parity.
        send_frame(8'h1C, 1'b1);
        chk("perr_set", bus.parity_err, 1);
        chk("perr_count", bus.kbd_count, 0);
        pulse_err_clr();
        chk("perr_clr", bus.parity_err, 0);

        // Overflow and pop+push on a full FIFO.
        for (int i = 0; i < FIFO_DEPTH + 1; i++) key(8'h1C);
        chk("full_count", bus.kbd_count, exp_q.size());
        chk("ovf_set", bus.overflow, exp_ovf);
        pulse_err_clr();
        exp_ovf = 1'b0;
        chk("ovf_clr", bus.overflow, 0);
        chk("full_head", bus.kbd, exp_next());
        model_code(8'h32);
        s0 = cyc;
        fork
            send_frame(8'h32, 1'b0);
            begin
                while (cyc < s0 + lat - 1) @(negedge clock);
                man_rd = 1'b1;
                @(negedge clock);
                man_rd = 0;
            end
        join
        chk("pp_count", bus.kbd_count, exp_q.size());
        chk("pp_ovf", bus.overflow, exp_ovf);
        for (int i = 0; i < FIFO_DEPTH; i++) pop_check("pp_drain");
        chk("pp_empty", bus.kbd_count, 0);

        // Timeout mid-frame, then spurious clock edge with data high.
        send_bits(11'b111_1010_1010, 5);
        ps2_dat = 1'b1;
        repeat (TIMEOUT_CYC + 30) @(negedge clock);
        chk("tmo_ferr", bus.frame_err, 1);
        chk("tmo_state", bus.rx_state, RX_IDLE);
        pulse_err_clr();
        chk("tmo_clr", bus.frame_err, 0);
        key(8'h29);
        pop_check("tmo_space");
        send_bits(11'h7FF, 1);
        repeat (IDLE) @(negedge clock);
        chk("idle_one_ferr", bus.frame_err, 1);
        pulse_err_clr();

        // Extended prefix.
        key(8'hE0); key(8'h6B); key(8'hE0); key(8'hF0); key(8'h6B);
        key(8'hE0); key(8'h12); key(8'h1E);
        chk("ext_count", bus.kbd_count, exp_q.size());
        while (exp_q.size() != 0) pop_check("ext_kbd");

        // kbd_clr mid-frame with a char queued, shift held and parity_err set.
        key(8'h12); key(8'h1C);
        send_frame(8'h24, 1'b1);
        send_bits({1'b1, 1'b0, 8'h1E, 1'b0}, 4);
        #2 kbd_clr = 1'b1;
        #1;
        chk("clr_kbd", bus.kbd, 0);
        chk("clr_count", bus.kbd_count, 0);
        chk("clr_perr", bus.parity_err, 0);
        chk("clr_state", bus.rx_state, RX_IDLE);
        @(negedge clock);
        kbd_clr = 1'b0;
        ps2_dat = 1'b1;
        exp_q.delete();
        m_shift = 1'b0; m_brk = 1'b0; m_ext = 1'b0;
        repeat (10) @(negedge clock);
        key(8'h1E);
        pop_check("clr_unshift");

        // Random key traffic drained by the monitor.
        auto_read = 1'b1;
        for (int n = 0; n < 60; n++) begin
            int r;
            logic [7:0] c;
            r = $urandom_range(0, 9);
            c = pool[$urandom_range(0, pool.size() - 1)];
            if (r == 0) key(8'hE0);
            if (r < 3) key(8'hF0);
            key(c);
            if (r == 9) begin
                send_frame(8'($urandom_range(0, 255)), 1'b1);
                chk("rnd_perr", bus.parity_err, 1);
                pulse_err_clr();
            end
        end
        for (int i = 0; i < 600 && (exp_q.size() != 0 || bus.kbd_count != '0); i++)
            @(negedge clock);
        chk("drain_q", exp_q.size(), 0);
        chk("drain_cnt", bus.kbd_count, 0);
        chk("end_ovf", bus.overflow, 0);
        chk("end_ferr", bus.frame_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
